// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the core's dmem interface. It services loads and stores
// issued from the MEMORY stage against a word-organised array of DEPTH 32-bit
// words located at byte address BASE_ADDR.
//
// Request semantics: a request is the single-cycle assertion of i_dmem_rd_en
// and/or i_dmem_wr_en together with address, type and data. There is no
// backpressure; every request is accepted in the cycle it is presented. A load
// returns combinationally in the same cycle. A store commits at the next
// posedge.
//
// Faulting accesses (reserved type, out of range, misaligned) are suppressed:
// a faulting store leaves the array untouched and a faulting load returns 0.
// The first fault is captured in a sticky error register until i_err_clr.
//
// Optional feature (macro DMEM_ACCESS_CNT_EN): adds free-running counters of
// non-faulting loads (o_rd_cnt) and stores (o_wr_cnt).
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            synchronous active-low reset
//   i_dmem_addr    byte address of the access
//   i_dmem_wdata   store data (low bytes used for SB/SH)
//   i_dmem_wr_type 00 SB, 01 SH, 10 SW, 11 reserved
//   i_dmem_rd_type 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others reserved
//   i_dmem_wr_en   store request
//   i_dmem_rd_en   load request
//   o_dmem_rdata   load result (combinational, 0 when no valid load)
//   i_err_clr      clears the error register
//   o_err          sticky error flag
//   o_err_cause    01 misaligned, 10 out-of-range, 11 reserved type
//   o_err_addr     address of the first faulting access
//   o_rd_cnt       (DMEM_ACCESS_CNT_EN) count of non-faulting loads
//   o_wr_cnt       (DMEM_ACCESS_CNT_EN) count of non-faulting stores
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_dmem_addr,
   input  logic [31:0] i_dmem_wdata,
   input  logic [1:0]  i_dmem_wr_type,
   input  logic [2:0]  i_dmem_rd_type,
   input  logic        i_dmem_wr_en,
   input  logic        i_dmem_rd_en,
   output logic [31:0] o_dmem_rdata,
   input  logic        i_err_clr,
   output logic        o_err,
   output logic [1:0]  o_err_cause,
   output logic [31:0] o_err_addr
`ifdef DMEM_ACCESS_CNT_EN
   ,
   output logic [31:0] o_rd_cnt,
   output logic [31:0] o_wr_cnt
`endif
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);

   // Cause codes are ordered so that a numerically larger code has higher
   // priority; combining two accesses is then a simple maximum.
   localparam logic [1:0] C_NONE  = 2'b00;
   localparam logic [1:0] C_MIS   = 2'b01;
   localparam logic [1:0] C_RANGE = 2'b10;
   localparam logic [1:0] C_TYPE  = 2'b11;

   logic [31:0]   mem [DEPTH];

   logic [31:0]   off;
   logic          in_range;
   logic [AW-1:0] idx;
   logic [1:0]    lane;

   logic [1:0]    wr_cause;
   logic [1:0]    rd_cause;
   logic [1:0]    wr_cause_g;
   logic [1:0]    rd_cause_g;
   logic [1:0]    fault_cause;
   logic          fault;
   logic          wr_ok;
   logic          rd_ok;

   logic [3:0]    wr_be;
   logic [31:0]   wr_lanes;
   logic [31:0]   rd_word;
   logic [15:0]   rd_half;

   // ---------------------------------------------------------------- decode
   assign off      = i_dmem_addr - BASE_ADDR;
   assign in_range = (off < SPAN);
   assign idx      = off[AW+1:2];
   assign lane     = off[1:0];

   always_comb begin
      wr_cause = C_NONE;
      if (i_dmem_wr_type == 2'b11) begin
         wr_cause = C_TYPE;
      end else if (!in_range) begin
         wr_cause = C_RANGE;
      end else if ((i_dmem_wr_type == 2'b01 && off[0]) ||
                   (i_dmem_wr_type == 2'b10 && off[1:0] != 2'b00)) begin
         wr_cause = C_MIS;
      end
   end

   always_comb begin
      rd_cause = C_NONE;
      if (!(i_dmem_rd_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
         rd_cause = C_TYPE;
      end else if (!in_range) begin
         rd_cause = C_RANGE;
      end else if ((i_dmem_rd_type[1:0] == 2'b01 && off[0]) ||
                   (i_dmem_rd_type[1:0] == 2'b10 && off[1:0] != 2'b00)) begin
         rd_cause = C_MIS;
      end
   end

   assign wr_cause_g  = i_dmem_wr_en ? wr_cause : C_NONE;
   assign rd_cause_g  = i_dmem_rd_en ? rd_cause : C_NONE;
   assign fault_cause = (wr_cause_g > rd_cause_g) ? wr_cause_g : rd_cause_g;
   assign fault       = (fault_cause != C_NONE);
   assign wr_ok       = i_dmem_wr_en && (wr_cause == C_NONE);
   assign rd_ok       = i_dmem_rd_en && (rd_cause == C_NONE);

   // ---------------------------------------------------------------- store
   // Store data is replicated across all lanes; the byte enables pick which
   // lanes actually change.
   always_comb begin
      wr_be    = 4'b1111;
      wr_lanes = i_dmem_wdata;
      case (i_dmem_wr_type)
         2'b00: begin
            wr_be    = 4'b0001 << lane;
            wr_lanes = {4{i_dmem_wdata[7:0]}};
         end
         2'b01: begin
            wr_be    = off[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{i_dmem_wdata[15:0]}};
         end
         default: begin
            wr_be    = 4'b1111;
            wr_lanes = i_dmem_wdata;
         end
      endcase
   end

   // Array contents survive reset; stores are only held off while rst is low.
   always_ff @(posedge clk) begin
      if (rst && wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------- load
   // For aligned halfwords the lane is 0 or 2, so one shift serves bytes and
   // halfwords alike. The read sees pre-write contents of a same-cycle store.
   assign rd_word = mem[idx];
   assign rd_half = 16'(rd_word >> {lane, 3'b000});

   always_comb begin
      o_dmem_rdata = 32'h0;
      if (rd_ok) begin
         case (i_dmem_rd_type)
            3'b000:  o_dmem_rdata = {{24{rd_half[7]}}, rd_half[7:0]};
            3'b001:  o_dmem_rdata = {{16{rd_half[15]}}, rd_half};
            3'b100:  o_dmem_rdata = {24'h0, rd_half[7:0]};
            3'b101:  o_dmem_rdata = {16'h0, rd_half};
            default: o_dmem_rdata = rd_word;
         endcase
      end
   end

   // ---------------------------------------------------------------- errors
   // A fault in the same cycle as i_err_clr wins and is captured as a fresh
   // first fault.
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_err       <= 1'b0;
         o_err_cause <= C_NONE;
         o_err_addr  <= 32'h0;
      end else if (fault) begin
         o_err <= 1'b1;
         if (!o_err || i_err_clr) begin
            o_err_cause <= fault_cause;
            o_err_addr  <= i_dmem_addr;
         end
      end else if (i_err_clr) begin
         o_err       <= 1'b0;
         o_err_cause <= C_NONE;
         o_err_addr  <= 32'h0;
      end
   end

`ifdef DMEM_ACCESS_CNT_EN
   // Free-running; wrap naturally and ignore i_err_clr.
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_rd_cnt <= 32'h0;
         o_wr_cnt <= 32'h0;
      end else begin
         if (rd_ok) o_rd_cnt <= o_rd_cnt + 32'd1;
         if (wr_ok) o_wr_cnt <= o_wr_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. A byte-addressed reference model is
// updated on every posedge; a compare process checks load data, the error
// register and (with DMEM_ACCESS_CNT_EN) the access counters on every negedge.
// Hand-computed literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          SPAN  = DEPTH * 4;

   localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                          LBU = 3'b100, LHU = 3'b101;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic [31:0] addr, wdata, rdata, err_addr;
   logic [1:0]  wr_type, err_cause;
   logic [2:0]  rd_type;
   logic        wr_en, rd_en, err_clr, err;
`ifdef DMEM_ACCESS_CNT_EN
   logic [31:0] rd_cnt, wr_cnt;
`endif

   dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_dmem_addr    (addr),
      .i_dmem_wdata   (wdata),
      .i_dmem_wr_type (wr_type),
      .i_dmem_rd_type (rd_type),
      .i_dmem_wr_en   (wr_en),
      .i_dmem_rd_en   (rd_en),
      .o_dmem_rdata   (rdata),
      .i_err_clr      (err_clr),
      .o_err          (err),
      .o_err_cause    (err_cause),
      .o_err_addr     (err_addr)
`ifdef DMEM_ACCESS_CNT_EN
      ,
      .o_rd_cnt       (rd_cnt),
      .o_wr_cnt       (wr_cnt)
`endif
   );

   // ---------------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------- model
   logic [7:0]  m_mem [SPAN];
   logic        m_err;
   logic [1:0]  m_cause;
   logic [31:0] m_addr;
   logic [31:0] m_rd_cnt, m_wr_cnt;
   bit          live = 0;

   function automatic int ld_size(input logic [2:0] t);
      case (t)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic int st_size(input logic [1:0] t);
      case (t)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   // Fault code of one access of n bytes; larger code means higher priority.
   function automatic logic [1:0] acc_cause(input int n, input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (n == 0) return 2'd3;
      if (off >= 32'(SPAN)) return 2'd2;
      if ((off % 32'(n)) != 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a);
      logic [31:0] off, v;
      int n;
      n = ld_size(t);
      if (acc_cause(n, a) != 0) return 32'h0;
      off = a - BASE;
      v = 32'h0;
      for (int i = 0; i < n; i++) v |= 32'(m_mem[int'(off) + i]) << (8 * i);
      if (!t[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   initial begin
      for (int i = 0; i < SPAN; i++) m_mem[i] = 8'h00;
   end

   always @(posedge clk) begin
      logic [1:0]  cr, cw, cf;
      logic [31:0] off;
      cr  = rd_en ? acc_cause(ld_size(rd_type), addr) : 2'd0;
      cw  = wr_en ? acc_cause(st_size(wr_type), addr) : 2'd0;
      cf  = (cr > cw) ? cr : cw;
      off = addr - BASE;
      if (!rst) begin
         m_err    = 1'b0;
         m_cause  = 2'd0;
         m_addr   = 32'h0;
         m_rd_cnt = 32'h0;
         m_wr_cnt = 32'h0;
         live     = 1;
      end else begin
         if (wr_en && cw == 0) begin
            for (int i = 0; i < st_size(wr_type); i++)
               m_mem[int'(off) + i] = wdata[8*i +: 8];
            m_wr_cnt++;
         end
         if (rd_en && cr == 0) m_rd_cnt++;
         if (cf != 0) begin
            if (!m_err || err_clr) begin
               m_cause = cf;
               m_addr  = addr;
            end
            m_err = 1'b1;
         end else if (err_clr) begin
            m_err   = 1'b0;
            m_cause = 2'd0;
            m_addr  = 32'h0;
         end
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk) begin
      if (live) begin
         check("rdata", rdata, rd_en ? m_load(rd_type, addr) : 32'h0);
         check("err", {31'h0, err}, {31'h0, m_err});
         check("err_cause", {30'h0, err_cause}, {30'h0, m_cause});
         check("err_addr", err_addr, m_addr);
`ifdef DMEM_ACCESS_CNT_EN
         check("rd_cnt", rd_cnt, m_rd_cnt);
         check("wr_cnt", wr_cnt, m_wr_cnt);
`endif
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic cyc(input logic we, input logic [1:0] wt, input logic re,
                      input logic [2:0] rt, input logic [31:0] a,
                      input logic [31:0] wd, input logic clr);
      @(posedge clk);
      #1;
      rst = 1'b1; wr_en = we; wr_type = wt; rd_en = re; rd_type = rt;
      addr = a; wdata = wd; err_clr = clr;
      @(negedge clk);
      #1;
   endtask

   task automatic st(input logic [1:0] wt, input logic [31:0] a, input logic [31:0] wd);
      cyc(1'b1, wt, 1'b0, LW, a, wd, 1'b0);
   endtask

   task automatic ld(input logic [2:0] rt, input logic [31:0] a);
      cyc(1'b0, SW, 1'b1, rt, a, 32'h0, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, SW, 1'b0, LW, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic clr_only();
      cyc(1'b0, SW, 1'b0, LW, 32'h0, 32'h0, 1'b1);
   endtask

   task automatic rst_cycle();
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      wr_type = SW; rd_type = LW; addr = 32'h0; wdata = 32'h0;
      @(negedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      wr_type = SW; rd_type = LW; addr = 32'h0; wdata = 32'h0;
      rst_cycle();
      rst_cycle();
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_cause", {30'h0, err_cause}, 32'h0);
      check("rst_addr", err_addr, 32'h0);

      st(SW, 32'h8, 32'h0);

      // word store, full and byte loads
      st(SW, 32'h10, 32'h8765_4321);
      ld(LW, 32'h10);  check("lw_10", rdata, 32'h8765_4321);
      ld(LB, 32'h13);  check("lb_13", rdata, 32'hFFFF_FF87);
      ld(LBU, 32'h13); check("lbu_13", rdata, 32'h0000_0087);

      // partial stores merge into one word
      st(SW, 32'h20, 32'hAABB_CCDD);
      st(SH, 32'h22, 32'h0000_1234);
      st(SB, 32'h20, 32'h0000_0055);
      ld(LW, 32'h20);  check("lw_20", rdata, 32'h1234_CC55);
      ld(LH, 32'h22);  check("lh_22", rdata, 32'h0000_1234);
      ld(LHU, 32'h20); check("lhu_20", rdata, 32'h0000_CC55);

      // last word in range
      st(SW, 32'hFFC, 32'hCAFE_F00D);
      ld(LW, 32'hFFC); check("lw_ffc", rdata, 32'hCAFE_F00D);
      ld(LB, 32'hFFF); check("lb_fff", rdata, 32'hFFFF_FFCA);

      // misaligned store suppressed, first fault kept
      st(SW, 32'h4, 32'h1111_1111);
      st(SH, 32'h5, 32'h0000_1234);
      ld(LW, 32'h4);
      check("lw_4_unchanged", rdata, 32'h1111_1111);
      check("mis_err", {31'h0, err}, 32'h1);
      check("mis_cause", {30'h0, err_cause}, 32'h1);
      check("mis_addr", err_addr, 32'h5);
      ld(LW, 32'(SPAN)); check("oor_rdata", rdata, 32'h0);
      idle();
      check("oor_keeps_cause", {30'h0, err_cause}, 32'h1);
      check("oor_keeps_addr", err_addr, 32'h5);

      // reserved type, clear, clear with simultaneous fault
      clr_only();
      ld(3'b011, 32'h0);
      check("rsv_rdata", rdata, 32'h0);
      check("clr_err", {31'h0, err}, 32'h0);
      idle();
      check("rsv_err", {31'h0, err}, 32'h1);
      check("rsv_cause", {30'h0, err_cause}, 32'h3);
      clr_only();
      idle();
      check("clr2_err", {31'h0, err}, 32'h0);
      cyc(1'b0, SW, 1'b1, LW, 32'h2, 32'h0, 1'b1);
      check("mis_lw_rdata", rdata, 32'h0);
      idle();
      check("clr_fault_err", {31'h0, err}, 32'h1);
      check("clr_fault_cause", {30'h0, err_cause}, 32'h1);
      check("clr_fault_addr", err_addr, 32'h2);

      // same-cycle load and store
      cyc(1'b1, SW, 1'b1, LW, 32'h8, 32'hDEAD_BEEF, 1'b0);
      check("rw_old", rdata, 32'h0);
      ld(LW, 32'h8); check("rw_new", rdata, 32'hDEAD_BEEF);

`ifdef DMEM_ACCESS_CNT_EN
      rst_cycle();
      ld(LW, 32'h10);
      ld(LB, 32'h13);
      ld(LHU, 32'h20);
      st(SW, 32'h30, 32'h0000_0001);
      st(SB, 32'h31, 32'h0000_0002);
      st(SH, 32'h33, 32'h0000_0003);
      idle();
      check("cnt_rd", rd_cnt, 32'd3);
      check("cnt_wr", wr_cnt, 32'd2);
      rst_cycle();
      check("cnt_rd_rst", rd_cnt, 32'd0);
      check("cnt_wr_rst", wr_cnt, 32'd0);
      ld(LW, 32'h10); check("retained", rdata, 32'h8765_4321);
`endif

      idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
